// File: rtl/window_scanner_2d.sv
// rtl/window_scanner_2d.sv - programmable 2D window coordinate scanner
// Walks a latched rectangle in row/column-major order with per-axis reversal.
module window_scanner_2d #(
   parameter int X_MAX = 240,
   parameter int Y_MAX = 320,
   localparam int XW = $clog2(X_MAX) + 1,
   localparam int YW = $clog2(Y_MAX) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [XW-1:0] x_start,
   input  logic [XW-1:0] x_end,
   input  logic [YW-1:0] y_start,
   input  logic [YW-1:0] y_end,
   input  logic          col_major,
   input  logic          x_rev,
   input  logic          y_rev,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [XW-1:0] out_x,
   output logic [YW-1:0] out_y,
   output logic          out_first,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t        state, state_next;
   logic [XW-1:0] xs_q, xe_q, x_q;
   logic [YW-1:0] ys_q, ye_q, y_q;
   logic          cm_q, xr_q, yr_q;
   logic          first_q, done_q, err_q;

   logic          window_ok, accept, xfer, last;
   logic          x_at_end, y_at_end;
   logic [XW-1:0] x_step, x_home;
   logic [YW-1:0] y_step, y_home;

   assign window_ok = (x_start <= x_end) && (x_end < XW'(X_MAX)) &&
                      (y_start <= y_end) && (y_end < YW'(Y_MAX));
   assign accept    = (state == IDLE) && start && !abort && window_ok;

   // Terminal detection is by equality only, so the extra width bit never wraps.
   assign x_at_end = (x_q == (xr_q ? xs_q : xe_q));
   assign y_at_end = (y_q == (yr_q ? ys_q : ye_q));
   assign x_step   = xr_q ? (x_q - XW'(1)) : (x_q + XW'(1));
   assign y_step   = yr_q ? (y_q - YW'(1)) : (y_q + YW'(1));
   assign x_home   = xr_q ? xe_q : xs_q;
   assign y_home   = yr_q ? ye_q : ys_q;

   assign last = (state == SCAN) && x_at_end && y_at_end;
   assign xfer = (state == SCAN) && out_ready && !abort;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = SCAN;
         SCAN: if (abort || (xfer && last)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         xs_q    <= '0;
         xe_q    <= '0;
         ys_q    <= '0;
         ye_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         cm_q    <= 1'b0;
         xr_q    <= 1'b0;
         yr_q    <= 1'b0;
         first_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= xfer && last;
         err_q  <= (state == IDLE) && start && !abort && !window_ok;
         if (accept) begin
            xs_q    <= x_start;
            xe_q    <= x_end;
            ys_q    <= y_start;
            ye_q    <= y_end;
            cm_q    <= col_major;
            xr_q    <= x_rev;
            yr_q    <= y_rev;
            x_q     <= x_rev ? x_end : x_start;
            y_q     <= y_rev ? y_end : y_start;
            first_q <= 1'b1;
         end else if (xfer) begin
            first_q <= 1'b0;
            // Coordinates hold on the final transfer so the last pixel stays visible.
            if (!last) begin
               if (cm_q) begin
                  if (y_at_end) begin
                     y_q <= y_home;
                     x_q <= x_step;
                  end else begin
                     y_q <= y_step;
                  end
               end else begin
                  if (x_at_end) begin
                     x_q <= x_home;
                     y_q <= y_step;
                  end else begin
                     x_q <= x_step;
                  end
               end
            end
         end
      end
   end

   assign out_valid = (state == SCAN);
   assign busy      = (state == SCAN);
   assign out_x     = x_q;
   assign out_y     = y_q;
   assign out_first = (state == SCAN) && first_q;
   assign out_last  = last;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_window_scanner_2d.sv
// tb/tb_window_scanner_2d.sv - self-checking bench for window_scanner_2d
// Reference queue of expected coordinates built from nested loops over the window.
module tb_window_scanner_2d;

   localparam int X_MAX = 240;
   localparam int Y_MAX = 320;
   localparam int XW = $clog2(X_MAX) + 1;
   localparam int YW = $clog2(Y_MAX) + 1;
   localparam int X2 = 256;
   localparam int XW2 = $clog2(X2) + 1;

   bit clk;
   logic reset, start, abort, col_major, x_rev, y_rev, out_ready;
   logic [XW-1:0] x_start, x_end, out_x;
   logic [YW-1:0] y_start, y_end, out_y;
   logic out_valid, out_first, out_last, busy, done, err;

   logic start2, abort2, ready2, valid2, first2, last2, busy2, done2, err2;
   logic [XW2-1:0] x2;
   logic [YW-1:0]  y2;

   always #5 clk = ~clk;

   window_scanner_2d #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
      .col_major(col_major), .x_rev(x_rev), .y_rev(y_rev),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
      .out_first(out_first), .out_last(out_last), .busy(busy), .done(done), .err(err));

   window_scanner_2d #(.X_MAX(X2), .Y_MAX(Y_MAX)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .abort(abort2),
      .x_start(XW2'(0)), .x_end(XW2'(X2 - 1)), .y_start(YW'(0)), .y_end(YW'(Y_MAX - 1)),
      .col_major(1'b0), .x_rev(1'b0), .y_rev(1'b0),
      .out_valid(valid2), .out_ready(ready2), .out_x(x2), .out_y(y2),
      .out_first(first2), .out_last(last2), .busy(busy2), .done(done2), .err(err2));

   typedef struct {int x; int y;} pt_t;
   pt_t q[$];
   int  idx, xfers, err_seen;
   bit  exp_done;
   int  total = 0, bad = 0;

   function automatic void check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void build(int xs, int xe, int ys, int ye, bit cm, bit xr, bit yr);
      pt_t p;
      q.delete();
      idx = 0;
      if (!cm) begin
         for (int j = 0; j <= ye - ys; j++)
            for (int i = 0; i <= xe - xs; i++) begin
               p.x = xr ? xe - i : xs + i;
               p.y = yr ? ye - j : ys + j;
               q.push_back(p);
            end
      end else begin
         for (int i = 0; i <= xe - xs; i++)
            for (int j = 0; j <= ye - ys; j++) begin
               p.x = xr ? xe - i : xs + i;
               p.y = yr ? ye - j : ys + j;
               q.push_back(p);
            end
      end
   endfunction

   // Per-cycle comparison against the reference queue.
   always @(negedge clk) begin
      bit nd;
      nd = 1'b0;
      check("done", int'(done), int'(exp_done));
      check("busy_eq_valid", int'(busy), int'(out_valid));
      if (err) err_seen++;
      if (out_valid) begin
         if (q.size() == 0) begin
            check("spurious_valid", 1, 0);
         end else begin
            check("out_x", int'(out_x), q[0].x);
            check("out_y", int'(out_y), q[0].y);
            check("out_first", int'(out_first), int'(idx == 0));
            check("out_last", int'(out_last), int'(q.size() == 1));
            if (out_ready && !abort && !reset) begin
               void'(q.pop_front());
               idx++;
               xfers++;
               if (q.size() == 0) nd = 1'b1;
            end
         end
      end
      exp_done = nd;
   end

   int  cnt2, ex2, ey2;
   bit  ok2, done2_seen;
   always @(negedge clk) begin
      if (valid2 && !reset) begin
         if (int'(x2) != ex2 || int'(y2) != ey2) ok2 = 1'b0;
         if (last2 != (cnt2 == X2 * Y_MAX - 1)) ok2 = 1'b0;
         if (first2 != (cnt2 == 0)) ok2 = 1'b0;
         cnt2++;
         if (ex2 == X2 - 1) begin ex2 = 0; ey2++; end
         else ex2++;
      end
      if (done2) done2_seen = 1'b1;
   end

   task automatic launch(int xs, int xe, int ys, int ye, bit cm, bit xr, bit yr);
      x_start = XW'(xs); x_end = XW'(xe); y_start = YW'(ys); y_end = YW'(ye);
      col_major = cm; x_rev = xr; y_rev = yr;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_to_end(int budget, bit rnd);
      int n;
      n = 0;
      while (q.size() > 0 && n < budget) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b1;
      check("scan_timeout", int'(q.size() > 0), 0);
   endtask

   task automatic wait_xfers(int target, int budget);
      int n;
      n = 0;
      while (xfers < target && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_timeout", int'(xfers < target), 0);
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_valid"}, int'(out_valid), 0);
      check({tag, "_x"}, int'(out_x), 0);
      check({tag, "_y"}, int'(out_y), 0);
      check({tag, "_first"}, int'(out_first), 0);
      check({tag, "_last"}, int'(out_last), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_err"}, int'(err), 0);
   endtask

   initial begin
      int x0, e0, n;
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      col_major = 1'b0; x_rev = 1'b0; y_rev = 1'b0;
      x_start = '0; x_end = '0; y_start = '0; y_end = '0;
      start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b1;
      ok2 = 1'b1; cnt2 = 0; ex2 = 0; ey2 = 0; done2_seen = 1'b0;
      xfers = 0; err_seen = 0; idx = 0; exp_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // Row-major basic window, with literal pins on the model.
      x0 = xfers;
      build(2, 3, 5, 6, 0, 0, 0);
      check("pin_rm0", q[0].x * 1000 + q[0].y, 2005);
      check("pin_rm1", q[1].x * 1000 + q[1].y, 3005);
      check("pin_rm2", q[2].x * 1000 + q[2].y, 2006);
      check("pin_rm3", q[3].x * 1000 + q[3].y, 3006);
      launch(2, 3, 5, 6, 0, 0, 0);
      run_to_end(50, 0);
      check("rm_xfers", xfers - x0, 4);

      // Back-to-back start during the done cycle: column-major, x reversed.
      check("done_now", int'(done), 1);
      x0 = xfers;
      build(2, 3, 5, 6, 1, 1, 0);
      check("pin_cm0", q[0].x * 1000 + q[0].y, 3005);
      check("pin_cm1", q[1].x * 1000 + q[1].y, 3006);
      check("pin_cm2", q[2].x * 1000 + q[2].y, 2005);
      check("pin_cm3", q[3].x * 1000 + q[3].y, 2006);
      launch(2, 3, 5, 6, 1, 1, 0);
      run_to_end(50, 0);
      check("cm_xfers", xfers - x0, 4);
      @(posedge clk); #1;

      // Backpressure on a 3x3 window with both axes reversed.
      x0 = xfers;
      build(7, 9, 1, 3, 0, 1, 1);
      launch(7, 9, 1, 3, 0, 1, 1);
      run_to_end(300, 1);
      check("bp_xfers", xfers - x0, 9);
      repeat (2) @(posedge clk); #1;

      // Invalid windows: reversed x range, then y_end out of range.
      e0 = err_seen;
      launch(10, 4, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk); #1;
      check("err_x", err_seen - e0, 1);
      check("err_x_busy", int'(busy), 0);
      launch(0, 0, 0, Y_MAX, 0, 0, 0);
      repeat (2) @(posedge clk); #1;
      check("err_y", err_seen - e0, 2);
      check("err_y_busy", int'(busy), 0);

      // 1x1 window.
      x0 = xfers;
      build(X_MAX - 1, X_MAX - 1, Y_MAX - 1, Y_MAX - 1, 0, 0, 0);
      launch(X_MAX - 1, X_MAX - 1, Y_MAX - 1, Y_MAX - 1, 0, 0, 0);
      run_to_end(10, 0);
      check("one_xfers", xfers - x0, 1);
      @(posedge clk); #1;

      // Abort after the third transfer of a 4x4 window.
      x0 = xfers;
      build(0, 3, 0, 3, 0, 0, 0);
      launch(0, 3, 0, 3, 0, 0, 0);
      wait_xfers(x0 + 3, 50);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      q.delete();
      @(negedge clk);
      check("abort_valid", int'(out_valid), 0);
      check("abort_busy", int'(busy), 0);
      @(negedge clk);
      check("abort_nodone", int'(done), 0);
      @(posedge clk); #1;
      x0 = xfers;
      build(1, 2, 1, 1, 0, 0, 0);
      launch(1, 2, 1, 1, 0, 0, 0);
      run_to_end(20, 0);
      check("post_abort_xfers", xfers - x0, 2);
      @(posedge clk); #1;

      // Reset mid-scan clears everything.
      x0 = xfers;
      build(0, 3, 0, 3, 0, 0, 0);
      launch(0, 3, 0, 3, 0, 0, 0);
      wait_xfers(x0 + 3, 50);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("midreset");
      q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      x0 = xfers;
      build(5, 5, 2, 4, 1, 0, 1);
      launch(5, 5, 2, 4, 1, 0, 1);
      run_to_end(20, 0);
      check("post_reset_xfers", xfers - x0, 3);
      @(posedge clk); #1;

      // Full screen on both instances concurrently.
      x0 = xfers;
      build(0, X_MAX - 1, 0, Y_MAX - 1, 0, 0, 0);
      check("pin_full_size", q.size(), 76800);
      check("pin_full_last", q[q.size() - 1].x * 1000 + q[q.size() - 1].y, 239319);
      start2 = 1'b1;
      launch(0, X_MAX - 1, 0, Y_MAX - 1, 0, 0, 0);
      start2 = 1'b0;
      run_to_end(80000, 0);
      check("full_xfers", xfers - x0, 76800);
      @(negedge clk);
      check("full_hold_x", int'(out_x), 239);
      check("full_hold_y", int'(out_y), 319);
      n = 0;
      while (!done2_seen && n < 10000) begin
         @(posedge clk); #1;
         n++;
      end
      check("w256_done", int'(done2_seen), 1);
      check("w256_xfers", cnt2, 81920);
      check("w256_seq_ok", int'(ok2), 1);
      check("w256_last_x", int'(x2), 255);
      check("w256_last_y", int'(y2), 319);
      check("w256_err", int'(err2), 0);
      check("w256_busy", int'(busy2), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/window_scanner_2d.md
Name: window_scanner_2d

Overview:
Generates the (x, y) pixel coordinate sequence for a programmable rectangular window on the display, replacing free-running full-screen counting. Supports row- or column-major order and per-axis reversal, matching the panel's address-window and memory-access-order settings. Sits between the frame/command sequencer (window setup) and the pixel source (coordinate consumer). Coordinates are delivered over a valid/ready handshake and framed by first/last flags.

Parameters:
X_MAX, 240, display width in pixels; legal x is 0..X_MAX-1
Y_MAX, 320, display height in pixels; legal y is 0..Y_MAX-1
XW, $clog2(X_MAX)+1 (localparam), x coordinate width; the extra bit covers power-of-two sizes
YW, $clog2(Y_MAX)+1 (localparam), y coordinate width; the extra bit covers power-of-two sizes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to latch the window and begin a scan
abort  in  1  terminate the current scan
x_start  in  XW  first column of the window, inclusive
x_end  in  XW  last column of the window, inclusive
y_start  in  YW  first row of the window, inclusive
y_end  in  YW  last row of the window, inclusive
col_major  in  1  0: x is the inner (fast) axis; 1: y is the inner axis
x_rev  in  1  scan x from x_end down to x_start
y_rev  in  1  scan y from y_end down to y_start
out_valid  out  1  coordinate is presented
out_ready  in  1  consumer accepts the coordinate
out_x  out  XW  current column
out_y  out  YW  current row
out_first  out  1  high with the first coordinate of the scan
out_last  out  1  high with the final coordinate of the scan
busy  out  1  scan in progress (state SCAN)
done  out  1  one-cycle pulse after the last coordinate is accepted
err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: state IDLE. All outputs are 0, including out_x, out_y, done and err.
- States: IDLE and SCAN.
- IDLE, start=1, window valid:
  - Window, col_major, x_rev and y_rev are latched.
  - Next cycle: state SCAN, busy=1, out_valid=1, out_first=1.
  - out_x = x_rev ? x_end : x_start; out_y = y_rev ? y_end : y_start.
- Window is valid iff x_start<=x_end<X_MAX and y_start<=y_end<Y_MAX.
- IDLE, start=1, window invalid: err pulses the next cycle, state stays IDLE, nothing is latched.
- start is ignored while in SCAN. Inputs other than out_ready and abort are ignored after latching.
- Transfer occurs when out_valid && out_ready. With out_ready=1 continuously, throughput is one coordinate per cycle.
- On each transfer the inner axis steps by +1, or -1 if that axis is reversed.
- When the inner axis passes its end:
  - The inner axis reloads its start value (x_end if reversed).
  - The outer axis steps by one in its own direction.
- out_first clears after the first transfer.
- out_last = 1 exactly when both axes sit at their terminal value (x_start if reversed, else x_end; same rule for y).
- A transfer with out_last=1 sets state IDLE, out_valid=0, busy=0 and pulses done the next cycle. out_x and out_y hold their last values.
- No output changes while out_valid=1 && out_ready=0 (AXI-style stability).
- 1x1 window: a single coordinate with out_first=out_last=1.
- Full-screen window (0..X_MAX-1, 0..Y_MAX-1) produces exactly X_MAX*Y_MAX transfers. There is no wrap beyond the end, so the extra XW/YW bit never overflows.
- abort, either state: next cycle state IDLE, out_valid=0, busy=0, no done pulse. abort beats a transfer in the same cycle, and beats start.
- reset mid-scan behaves as abort and also clears all outputs.
- start on the same cycle that done is asserted is accepted, because the block is already in IDLE.
- Arithmetic: next-values are computed at XW/YW width. Terminal detection uses equality compares only, never overflow.

Test Plan:
- Basic row-major: window x 2..3, y 5..6, out_ready=1.
  -> Sequence (2,5)(3,5)(2,6)(3,6); first flagged on (2,5), last on (3,6); done one cycle after (3,6); 4 transfers.
- Column-major plus reversal: same window, col_major=1, x_rev=1.
  -> Sequence (3,5)(3,6)(2,5)(2,6).
- Backpressure: out_ready toggled pseudo-randomly on a 3x3 window.
  -> Each coordinate is held stable while stalled; 9 unique transfers in order.
- Invalid window: x_start=10, x_end=4, then a separate start with y_end=Y_MAX.
  -> err pulses once per request; busy stays 0; no out_valid.
- Abort and reset: abort after the 3rd transfer of a 4x4 window.
  -> out_valid=0 the next cycle, no done; a new start then works. Repeat using reset, which also returns all outputs to 0.
- Full screen: X_MAX=240, Y_MAX=320, window 0..239 by 0..319, with X_MAX=256 as a second run.
  -> 76800 transfers, last=(239,319), done pulse; the 256 case also works without overflow.
